multiplicador_secuencial: RTL and testbench
===========================================

Name: multiplicador_secuencial

Overview:
Unsigned shift-and-add multiplier. Consumes ANCHO-bit operands and produces a 2*ANCHO-bit product over ANCHO iterations, one iteration per clock.
Each iteration performs one ANCHO-bit add with carry-out, then a right shift.
Sits directly downstream of the ALU's ripple-carry adder stage and reuses that add-with-carry function as its datapath core.
Start/done handshake to the ALU control logic.

Parameters:
ANCHO, 4, operand width in bits; product is 2*ANCHO bits; must be >= 2.

Ports:
clk  input  1  single clock, rising-edge active
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
A  input  ANCHO  multiplicand, captured on accepted start
B  input  ANCHO  multiplier, captured on accepted start
P  output  2*ANCHO  product; valid when done=1, held until the next accepted start
done  output  1  one-cycle pulse, high in the cycle P becomes valid
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (async, rst=1): state=IDLE, acc=0, Q=0, M=0, cnt=0, P=0, done=0, busy=0. Reset takes effect immediately, mid-operation included; the in-flight result is discarded.
- Registers:
  - M: ANCHO-bit multiplicand.
  - acc: ANCHO-bit upper partial product.
  - Q: ANCHO-bit lower partial product / multiplier.
  - cnt: counter, width $clog2(ANCHO+1).
  - P_reg: output register.
- IDLE: busy=0, done=0.
  - start=1 at edge t0 -> M<=A, Q<=B, acc<=0, cnt<=0, state<=CALC.
  - start=0 -> stay in IDLE.
- CALC: busy=1. Each edge:
  - {c,s} = Q[0] ? acc+M (ANCHO+1 bits, carry-in 0) : {0,acc}.
  - {acc,Q} <= {c,s,Q} >> 1, i.e. acc<={c,s[ANCHO-1:1]}, Q<={s[0],Q[ANCHO-1:1]}.
  - cnt<=cnt+1.
  - When cnt==ANCHO-1 on this edge: state<=DONE, P_reg<={c,s,Q}>>1 (the final shifted value).
- DONE: busy=1, done=1, P=P_reg. Next edge: state<=IDLE unconditionally.
- Latency, accepted start at edge t0: iterations at t1..tANCHO; done=1 for exactly one cycle between t(ANCHO) and t(ANCHO+1); IDLE from t(ANCHO+1). Default ANCHO=4 gives done 4 edges after the accepting edge.
- Earliest next accept is t(ANCHO+2); start held high continuously yields one operation every ANCHO+2 cycles.
- start while busy=1: ignored, no queuing. A and B may change freely after the accepting edge; only the captured values are used.
- P holds its last value through IDLE until overwritten at the end of the next operation. P is not cleared on start.
- Overflow is impossible: the ANCHO+1-bit sum is fully absorbed by the shift. Max product (2^ANCHO-1)^2 fits in 2*ANCHO bits.
- Unsigned only. Operands of zero still take the full ANCHO iterations; no early termination.

Decomposition:
- Package multiplicador_pkg:
  - Enum estado_t {IDLE, CALC, DONE}, 2 bits.
  - Default ANCHO constant.
  - Function for the counter width.
- Sub-module sumador_n_bits (parameter ANCHO):
  - Purely combinational.
  - Ports A, B, Cin, R, Cout; behaves as an ANCHO-bit ripple-carry adder.
  - Instantiated once with Cin tied to 0.
- All sequential logic (FSM, counter, shift registers, P_reg) lives in multiplicador_secuencial.

Test Plan:
- Reset then A=0xD, B=0xB, start pulse 1 cycle -> busy=1 next cycle; done=1 exactly 4 edges after accept; P=0x8F; busy=0 one cycle later.
- A=0xF, B=0xF -> P=0xE1. A=0x0, B=0x9 -> P=0x00 after the full 4 iterations. A=0xA, B=0x3 -> P=0x1E.
- During CALC, change A/B and pulse start -> ignored; result still the product of the captured operands. A second done pulse never appears.
- start held high constantly with A=0x2, B=0x3 -> done pulses every 6 cycles; P=0x06 each time.
- rst asserted asynchronously mid-CALC (between edges) -> state, P, done and busy clear immediately without a clock. After release, a new op A=0x7, B=0x7 -> P=0x31.
- Exhaustive sweep of all 256 operand pairs against a reference model -> every P matches A*B; done width is always 1 cycle.

Source files
------------

// File: rtl/multiplicador_pkg.sv
// Shared types and constants for the sequential shift-and-add multiplier.
package multiplicador_pkg;

    localparam int unsigned ANCHO_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } estado_t;

    // Iteration counter must be able to hold the value ANCHO.
    function automatic int unsigned ancho_cnt(input int unsigned ancho);
        return $clog2(ancho + 1);
    endfunction

endpackage

// File: rtl/multiplicador_secuencial_if.sv
// Start/done handshake and operand/product bus between ALU control and the multiplier.
interface multiplicador_secuencial_if
    import multiplicador_pkg::*;
#(
    parameter int unsigned ANCHO = ANCHO_DEF
);
    logic                   start;
    logic [ANCHO-1:0]       A;
    logic [ANCHO-1:0]       B;
    logic [2*ANCHO-1:0]     P;
    logic                   done;
    logic                   busy;

    modport master (output start, A, B, input P, done, busy);
    modport slave  (input start, A, B, output P, done, busy);
endinterface

// File: rtl/sumador_n_bits.sv
// Combinational ANCHO-bit ripple-carry adder, shared with the ALU adder stage.
module sumador_n_bits
    import multiplicador_pkg::*;
#(
    parameter int unsigned ANCHO = ANCHO_DEF
) (
    input  logic [ANCHO-1:0] A,
    input  logic [ANCHO-1:0] B,
    input  logic             Cin,
    output logic [ANCHO-1:0] R,
    output logic             Cout
);
    logic [ANCHO:0] carry;

    assign carry[0] = Cin;

    for (genvar i = 0; i < ANCHO; i++) begin : g_fa
        assign R[i]       = A[i] ^ B[i] ^ carry[i];
        assign carry[i+1] = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
    end

    assign Cout = carry[ANCHO];
endmodule

// File: rtl/multiplicador_secuencial.sv
// Unsigned shift-and-add multiplier: one add-with-carry plus right shift per clock,
// ANCHO iterations per product, start/done handshake.
module multiplicador_secuencial
    import multiplicador_pkg::*;
#(
    parameter int unsigned ANCHO = ANCHO_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    multiplicador_secuencial_if.slave bus
);
    localparam int unsigned CW = ancho_cnt(ANCHO);
    localparam int unsigned PW = 2 * ANCHO;

    estado_t           state_q, state_d;
    logic [ANCHO-1:0]  m_q, m_d;
    logic [ANCHO-1:0]  acc_q, acc_d;
    logic [ANCHO-1:0]  q_q, q_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [PW-1:0]     p_q, p_d;
    logic              done_q, busy_q;

    logic [ANCHO-1:0]  sumando;
    logic [ANCHO-1:0]  suma;
    logic              carry;
    logic [ANCHO-1:0]  acc_sh;
    logic [ANCHO-1:0]  q_sh;

    // Multiplicand is added only when the current multiplier LSB is set.
    assign sumando = q_q[0] ? m_q : '0;

    sumador_n_bits #(.ANCHO(ANCHO)) u_sumador (
        .A    (acc_q),
        .B    (sumando),
        .Cin  (1'b0),
        .R    (suma),
        .Cout (carry)
    );

    // {carry, suma, Q} shifted right by one; the carry is absorbed into acc's MSB.
    assign acc_sh = {carry, suma[ANCHO-1:1]};
    assign q_sh   = {suma[0], q_q[ANCHO-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            m_q     <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            done_q  <= (state_d == DONE);
            busy_q  <= (state_d != IDLE);
        end
    end

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        acc_d   = acc_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        p_d     = p_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    m_d     = bus.A;
                    q_d     = bus.B;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d = acc_sh;
                q_d   = q_sh;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(ANCHO - 1)) begin
                    p_d     = {acc_sh, q_sh};
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.P    = p_q;
    assign bus.done = done_q;
    assign bus.busy = busy_q;
endmodule

// File: tb/tb_multiplicador_secuencial.sv
// Self-checking bench for multiplicador_secuencial: cycle-level reference model plus
// directed operations with hand-computed products.
module tb_multiplicador_secuencial;
    localparam int unsigned ANCHO = 4;
    localparam int unsigned W     = 2 * ANCHO;

    logic clk;
    logic rst;
    int   ncheck;
    int   nerr;

    multiplicador_secuencial_if #(.ANCHO(ANCHO)) bus ();

    multiplicador_secuencial #(.ANCHO(ANCHO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncheck++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: phase counts cycles since the accepting edge (0 = idle).
    int            fase;
    logic [W-1:0]  pend_p;
    logic [W-1:0]  exp_p;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            fase   <= 0;
            pend_p <= '0;
            exp_p  <= '0;
        end else if (fase == 0) begin
            if (bus.start === 1'b1) begin
                pend_p <= W'(bus.A) * W'(bus.B);
                fase   <= 1;
            end
        end else if (fase == ANCHO + 1) begin
            fase <= 0;
        end else begin
            fase <= fase + 1;
            if (fase == ANCHO) exp_p <= pend_p;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("model_P",    32'(bus.P),    32'(exp_p));
            chk("model_done", 32'(bus.done), 32'(fase == ANCHO + 1));
            chk("model_busy", 32'(bus.busy), 32'(fase != 0));
        end
    end

    task automatic run_op(input logic [ANCHO-1:0] a, input logic [ANCHO-1:0] b,
                          input logic [W-1:0] exp, input string tag);
        int n;
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = a;
        bus.B     = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.A     = ANCHO'($urandom);
        bus.B     = ANCHO'($urandom);
        chk({tag, "_busy_after_accept"}, 32'(bus.busy), 32'd1);
        n = 1;
        while (bus.done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'(ANCHO + 1));
        chk({tag, "_P"}, 32'(bus.P), 32'(exp));
        @(negedge clk);
        chk({tag, "_busy_cleared"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int dones;
        int last;
        ncheck    = 0;
        nerr      = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;

        #2;
        chk("reset_P",    32'(bus.P),    32'd0);
        chk("reset_done", 32'(bus.done), 32'd0);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        #1 rst = 1'b0;

        run_op(4'hD, 4'hB, 8'h8F, "d_x_b");
        run_op(4'hF, 4'hF, 8'hE1, "f_x_f");
        run_op(4'h0, 4'h9, 8'h00, "0_x_9");
        run_op(4'hA, 4'h3, 8'h1E, "a_x_3");

        // Start pulse and operand change during CALC must be ignored.
        @(negedge clk);
        bus.start = 1'b1; bus.A = 4'hC; bus.B = 4'h5;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.A = 4'hF; bus.B = 4'hF;
        @(negedge clk);
        bus.start = 1'b0;
        n = 3;
        while (bus.done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ignore_latency", 32'(n), 32'(ANCHO + 1));
        chk("ignore_P", 32'(bus.P), 32'h3C);
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) dones++;
        end
        chk("ignore_no_second_done", 32'(dones), 32'd0);

        // Start held high: one result every ANCHO+2 cycles.
        @(negedge clk);
        bus.start = 1'b1; bus.A = 4'h2; bus.B = 4'h3;
        n = 0; dones = 0; last = 0;
        while (dones < 4 && n < 40) begin
            @(negedge clk);
            n++;
            if (bus.done === 1'b1) begin
                chk("held_P", 32'(bus.P), 32'h06);
                if (dones > 0) chk("held_period", 32'(n - last), 32'(ANCHO + 2));
                else           chk("held_first", 32'(n), 32'(ANCHO + 1));
                last = n;
                dones++;
            end
        end
        bus.start = 1'b0;
        chk("held_count", 32'(dones), 32'd4);
        @(negedge clk);

        // Asynchronous reset between edges during CALC.
        @(negedge clk);
        bus.start = 1'b1; bus.A = 4'hF; bus.B = 4'hF;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_P",    32'(bus.P),    32'd0);
        chk("async_rst_done", 32'(bus.done), 32'd0);
        chk("async_rst_busy", 32'(bus.busy), 32'd0);
        #1 rst = 1'b0;
        run_op(4'h7, 4'h7, 8'h31, "7_x_7");

        // Every operand pair.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_op(ANCHO'(a), ANCHO'(b), W'(a * b), "sweep");
            end
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", ncheck, nerr);
        $finish;
    end
endmodule
